lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_if.sv | 34 +++
 rtl/lsu_align.sv | 30 +++
 rtl/lsu.sv | 93 +++++++++
 tb/tb_lsu.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, load/store op encodings and request-legality helpers for the LSU.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [2:0] LS_B  = 3'd0;
   localparam logic [2:0] LS_H  = 3'd1;
   localparam logic [2:0] LS_W  = 3'd2;
   localparam logic [2:0] LS_D  = 3'd3;
   localparam logic [2:0] LS_BU = 3'd4;
   localparam logic [2:0] LS_HU = 3'd5;
   localparam logic [2:0] LS_WU = 3'd6;

   function automatic logic [7:0] size_mask(input logic [2:0] op);
      case (op[1:0])
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // Misaligned access, reserved op 7, or a store using an unsigned load op.
   function automatic logic ls_illegal(input logic we, input logic [2:0] op, input logic [2:0] off);
      logic bad;
      bad = 1'b0;
      case (op)
         LS_B, LS_BU: bad = 1'b0;
         LS_H, LS_HU: bad = off[0];
         LS_W, LS_WU: bad = |off[1:0];
         LS_D:        bad = |off;
         default:     bad = 1'b1;
      endcase
      if (we && op[2]) bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, memory and response signals of the LSU; slave is the LSU view, master the environment view.
interface lsu_if #(parameter int XLEN = 64);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_we;
   logic [XLEN-1:0] mem_req_addr;
   logic [XLEN-1:0] mem_req_wdata;
   logic [7:0]      mem_req_wstrb;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_rdata;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_err;

   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      output resp_valid, resp_rdata, resp_err
   );

   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      input  resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_align.sv
// Load lane extraction: shifts the addressed bytes down and sign/zero-extends to the access size.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      op,
   input  logic [2:0]      off,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] lane;

   assign lane = rdata >> {off, 3'b000};

   always_comb begin
      data = lane;
      case (op)
         LS_B:    data = {{(XLEN-8){lane[7]}},   lane[7:0]};
         LS_H:    data = {{(XLEN-16){lane[15]}}, lane[15:0]};
         LS_W:    data = {{(XLEN-32){lane[31]}}, lane[31:0]};
         LS_BU:   data = {{(XLEN-8){1'b0}},      lane[7:0]};
         LS_HU:   data = {{(XLEN-16){1'b0}},     lane[15:0]};
         LS_WU:   data = {{(XLEN-32){1'b0}},     lane[31:0]};
         default: data = lane;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access to a doubleword memory port, with lane shifting and extension.
//
//  state | meaning
//  IDLE  | req_ready high, waiting for a load/store
//  REQ   | mem_req_valid high, holding the request until mem_req_ready
//  WAIT  | waiting for mem_rsp_valid; read lane captured on arrival
//  RESP  | one-cycle resp_valid pulse (also entered directly for illegal requests)
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic  clk,
   input  logic  rst_n,
   lsu_if.slave  bus
);

   state_t          state;
   logic            we_q;
   logic [2:0]      op_q;
   logic [2:0]      off_q;
   logic [XLEN-1:0] load_data;

   lsu_align #(.XLEN(XLEN)) u_align (
      .rdata (bus.mem_rsp_rdata),
      .op    (op_q),
      .off   (off_q),
      .data  (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         we_q              <= 1'b0;
         op_q              <= 3'd0;
         off_q             <= 3'd0;
         bus.req_ready     <= 1'b1;
         bus.mem_req_valid <= 1'b0;
         bus.mem_req_we    <= 1'b0;
         bus.mem_req_addr  <= '0;
         bus.mem_req_wdata <= '0;
         bus.mem_req_wstrb <= 8'h00;
         bus.resp_valid    <= 1'b0;
         bus.resp_rdata    <= '0;
         bus.resp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q          <= bus.req_we;
                  op_q          <= bus.req_op;
                  off_q         <= bus.req_addr[2:0];
                  bus.req_ready <= 1'b0;
                  if (ls_illegal(bus.req_we, bus.req_op, bus.req_addr[2:0])) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= '0;
                  end else begin
                     state             <= REQ;
                     bus.mem_req_valid <= 1'b1;
                     bus.mem_req_we    <= bus.req_we;
                     bus.mem_req_addr  <= {bus.req_addr[XLEN-1:3], 3'b000};
                     bus.mem_req_wdata <= bus.req_we ? (bus.req_wdata << {bus.req_addr[2:0], 3'b000}) : '0;
                     bus.mem_req_wstrb <= bus.req_we ? (size_mask(bus.req_op) << bus.req_addr[2:0]) : 8'hFF;
                  end
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  bus.mem_req_valid <= 1'b0;
                  state             <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_rsp_valid) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= we_q ? '0 : load_data;
               end
            end
            RESP: begin
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against an arithmetic reference model of the load/store rules.
module tb_lsu;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_if bus ();

   lsu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_chk = 0;
   int          n_bad = 0;
   logic [63:0] last_rdata;
   bit          rdata_known = 1'b1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned m_size(input logic [2:0] op);
      return 1 << (op % 4);
   endfunction

   function automatic bit m_err(input bit we, input logic [2:0] op, input logic [63:0] addr);
      if (op == 3'd7) return 1'b1;
      if (we && op >= 3'd4) return 1'b1;
      return (addr % m_size(op)) != 0;
   endfunction

   function automatic logic [7:0] m_strb(input bit we, input logic [2:0] op, input logic [63:0] addr);
      longint unsigned m;
      if (!we) return 8'hFF;
      m = ((64'd1 << m_size(op)) - 1) << (addr % 8);
      return 8'(m);
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] rdata);
      longint unsigned v;
      int unsigned     nbits;
      v     = rdata >> (8 * (addr % 8));
      nbits = 8 * m_size(op);
      if (nbits < 64) begin
         v = v % (64'd1 << nbits);
         if (op < 3'd3 && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
      end
      return v;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         bus.mem_rsp_valid = 1'($urandom % 2);
         bus.mem_rsp_rdata = rnd64();
         @(posedge clk); #1;
         chk("idle_resp_valid", bus.resp_valid, 1'b0);
         chk("idle_req_ready", bus.req_ready, 1'b1);
         if (rdata_known) chk("idle_rdata_hold", bus.resp_rdata, last_rdata);
      end
      bus.mem_rsp_valid = 1'b0;
   endtask

   // Called just after a rising edge with the DUT idle; returns in the same phase, DUT idle again.
   task automatic do_txn(input bit we, input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int rdly, input int wdly, input bit stray);
      bit          err;
      logic [63:0] exp_addr, exp_wdata, exp_res;
      logic [7:0]  exp_strb;
      err       = m_err(we, op, addr);
      exp_addr  = addr - (addr % 8);
      exp_strb  = m_strb(we, op, addr);
      exp_wdata = wdata << (8 * (addr % 8));
      exp_res   = we ? 64'd0 : m_load(op, addr, rdata);

      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      chk("req_ready_idle", bus.req_ready, 1'b1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom % 2);
      bus.req_op    = 3'($urandom % 8);
      bus.req_addr  = rnd64();
      bus.req_wdata = rnd64();
      chk("req_ready_busy", bus.req_ready, 1'b0);

      if (err) begin
         chk("err_resp_valid", bus.resp_valid, 1'b1);
         chk("err_resp_err", bus.resp_err, 1'b1);
         chk("err_no_mem_req", bus.mem_req_valid, 1'b0);
         @(posedge clk); #1;
         chk("err_pulse_end", bus.resp_valid, 1'b0);
         chk("err_flag_hold", bus.resp_err, 1'b1);
         chk("err_no_mem_req2", bus.mem_req_valid, 1'b0);
         rdata_known = 1'b0;
         return;
      end

      for (int i = 0; i <= rdly; i++) begin
         chk("mem_req_valid", bus.mem_req_valid, 1'b1);
         chk("mem_req_addr", bus.mem_req_addr, exp_addr);
         chk("mem_req_we", bus.mem_req_we, we);
         chk("mem_req_wstrb", bus.mem_req_wstrb, exp_strb);
         if (we) chk("mem_req_wdata", bus.mem_req_wdata, exp_wdata);
         chk("req_no_resp", bus.resp_valid, 1'b0);
         if (i < rdly) begin
            bus.mem_rsp_valid = stray && (i == 0);
            bus.mem_rsp_rdata = rnd64();
            @(posedge clk); #1;
            bus.mem_rsp_valid = 1'b0;
         end
      end
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'($urandom % 2);
      chk("wait_mem_req_drop", bus.mem_req_valid, 1'b0);
      for (int i = 0; i < wdly; i++) begin
         chk("wait_no_resp", bus.resp_valid, 1'b0);
         @(posedge clk); #1;
      end
      chk("wait_no_resp_last", bus.resp_valid, 1'b0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = rdata;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = rnd64();
      bus.mem_req_ready = 1'b0;
      chk("resp_valid", bus.resp_valid, 1'b1);
      chk("resp_err", bus.resp_err, 1'b0);
      chk("resp_rdata", bus.resp_rdata, exp_res);
      @(posedge clk); #1;
      chk("resp_pulse_end", bus.resp_valid, 1'b0);
      chk("resp_rdata_hold", bus.resp_rdata, exp_res);
      chk("back_to_idle", bus.req_ready, 1'b1);
      last_rdata  = exp_res;
      rdata_known = 1'b1;
   endtask

   initial begin
      logic [2:0]  op;
      logic [63:0] addr;
      bit          we;

      bus.req_valid     = 1'b0;
      bus.req_we        = 1'b0;
      bus.req_op        = 3'd0;
      bus.req_addr      = '0;
      bus.req_wdata     = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      last_rdata        = '0;

      #12;
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      chk("rst_mem_req_wstrb", bus.mem_req_wstrb, 8'h00);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
      chk("rst_resp_err", bus.resp_err, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed cases
      do_txn(1'b0, 3'd3, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 1'b0);
      do_txn(1'b0, 3'd0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
      chk("lb_value", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      do_txn(1'b0, 3'd4, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
      chk("lbu_value", last_rdata, 64'h80);
      do_txn(1'b1, 3'd1, 64'h8000_0006, 64'hABCD, rnd64(), 0, 0, 1'b0);
      do_txn(1'b0, 3'd2, 64'h8000_0002, 64'd0, rnd64(), 0, 0, 1'b0);
      do_txn(1'b1, 3'd4, 64'h8000_0000, rnd64(), rnd64(), 0, 0, 1'b0);
      do_txn(1'b0, 3'd7, 64'h8000_0000, 64'd0, rnd64(), 0, 0, 1'b0);
      do_txn(1'b0, 3'd3, 64'h8000_0008, 64'd0, rnd64(), 5, 0, 1'b1);
      do_txn(1'b1, 3'd3, 64'h8000_0018, rnd64(), rnd64(), 5, 2, 1'b1);

      // reset while waiting for a memory response
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_op    = 3'd3;
      bus.req_addr  = 64'h8000_0020;
      @(posedge clk); #1;
      bus.req_valid     = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req_ready", bus.req_ready, 1'b1);
      chk("arst_mem_req_valid", bus.mem_req_valid, 1'b0);
      chk("arst_resp_valid", bus.resp_valid, 1'b0);
      chk("arst_resp_rdata", bus.resp_rdata, 64'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = rnd64();
      @(posedge clk); #1;
      chk("arst_held_no_resp", bus.resp_valid, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_after_no_resp", bus.resp_valid, 1'b0);
      chk("arst_after_ready", bus.req_ready, 1'b1);
      bus.mem_rsp_valid = 1'b0;
      last_rdata  = 64'd0;
      rdata_known = 1'b1;
      do_txn(1'b0, 3'd1, 64'h8000_0022, 64'd0, rnd64(), 1, 1, 1'b0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         op   = 3'($urandom % 8);
         we   = 1'($urandom % 2);
         addr = rnd64();
         if ($urandom % 4 != 0) addr = addr - (addr % m_size(op));
         do_txn(we, op, addr, rnd64(), rnd64(), int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2));
         idle_gap(int'($urandom % 3));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
